// File: rtl/alsu_pipe_if.sv
// rtl/alsu_pipe_if.sv - stream handshake and operand/result bundle for alsu_pipe
// Purpose: groups the input transaction, output result and status signals of alsu_pipe.
// Ports (signals):
//   in_valid/in_ready                      input handshake
//   A, B, Cin, serial_in, red_op_A/B,
//   opcode, bypass_A/B, direction          input transaction fields
//   out_valid/out_ready                    output handshake
//   out, err, leds, err_cnt                result and status
// Modports: master drives transactions and consumes results, slave is the ALSU.
interface alsu_pipe_if #(
  parameter int WIDTH = 4
);
  localparam int OW = 2 * WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             serial_in;
  logic             red_op_A;
  logic             red_op_B;
  logic [2:0]       opcode;
  logic             bypass_A;
  logic             bypass_B;
  logic             direction;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    out;
  logic             err;
  logic [15:0]      leds;
  logic [7:0]       err_cnt;

  modport master (
    output in_valid, A, B, Cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    input  in_ready, out_valid, out, err, leds, err_cnt
  );

  modport slave (
    input  in_valid, A, B, Cin, serial_in, red_op_A, red_op_B, opcode,
           bypass_A, bypass_B, direction, out_ready,
    output in_ready, out_valid, out, err, leds, err_cnt
  );
endinterface

// File: rtl/alsu_pipe.sv
// rtl/alsu_pipe.sv - two-stage pipelined ALSU with valid/ready handshakes
// Purpose: WIDTH-bit signed operands, 2*WIDTH-bit result; stage 1 captures the
//   transaction, stage 2 evaluates it into the registered result.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-low
//   bus   alsu_pipe_if.slave (handshakes, operands, result, err, leds, err_cnt)
// Parameters: WIDTH, INPUT_PRIORITY ("A"/"B"), FULL_ADDER ("ON"/"OFF").
// Build option: define ALSU_ERR_CNT_EN to enable the saturating invalid-result counter.
module alsu_pipe #(
  parameter int    WIDTH          = 4,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input logic      clk,
  input logic      rst,
  alsu_pipe_if.slave bus
);
  localparam int OW      = 2 * WIDTH;
  localparam bit PRI_A   = (INPUT_PRIORITY == "A");
  localparam bit ADD_CIN = (FULL_ADDER == "ON");

  // Stage 1: captured transaction
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_serial;
  logic             s1_red_a;
  logic             s1_red_b;
  logic [2:0]       s1_op;
  logic             s1_byp_a;
  logic             s1_byp_b;
  logic             s1_dir;

  // Stage 2: registered result
  logic             out_valid_r;
  logic [OW-1:0]    out_r;
  logic             err_r;
  logic [15:0]      leds_r;

  logic             load_s2;
  logic             in_ready_w;
  logic             accept;
  logic             invalid;
  logic [OW-1:0]    a_ext;
  logic [OW-1:0]    b_ext;
  logic [OW-1:0]    cin_ext;
  logic [WIDTH-1:0] red_x;
  logic [OW-1:0]    res;

  // S2 accepts when empty or when its current result leaves this cycle, so a
  // full pipe still moves one transaction per cycle.
  assign load_s2    = s1_valid & (~out_valid_r | bus.out_ready);
  assign in_ready_w = rst & (~s1_valid | load_s2);
  assign accept     = bus.in_valid & in_ready_w;

  assign a_ext   = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
  assign b_ext   = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
  assign cin_ext = {{(OW-1){1'b0}}, s1_cin & ADD_CIN};

  // Reduction operand: B only when it is the sole flag or B has priority.
  assign red_x = (s1_red_a & (PRI_A | ~s1_red_b)) ? s1_a : s1_b;

  // Reductions are only legal on the two logic opcodes.
  assign invalid = (s1_op[2:1] == 2'b11) |
                   ((s1_red_a | s1_red_b) & (s1_op[2:1] != 2'b00));

  always_comb begin
    res = '0;
    if (invalid) begin
      res = '0;
    end else if (s1_byp_a | s1_byp_b) begin
      res = (s1_byp_a & (PRI_A | ~s1_byp_b)) ? a_ext : b_ext;
    end else begin
      case (s1_op)
        3'b000: res = (s1_red_a | s1_red_b) ? {{(OW-1){1'b0}}, |red_x} : (a_ext | b_ext);
        3'b001: res = (s1_red_a | s1_red_b) ? {{(OW-1){1'b0}}, ^red_x} : (a_ext ^ b_ext);
        // Sign-extended operands keep both the sum and the low OW bits of
        // the product exact for signed inputs.
        3'b010: res = a_ext + b_ext + cin_ext;
        3'b011: res = a_ext * b_ext;
        // Shift/rotate act on whatever result currently sits in the out register.
        3'b100: res = s1_dir ? {out_r[OW-2:0], s1_serial} : {s1_serial, out_r[OW-1:1]};
        3'b101: res = s1_dir ? {out_r[OW-2:0], out_r[OW-1]} : {out_r[0], out_r[OW-1:1]};
        default: res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_cin      <= 1'b0;
      s1_serial   <= 1'b0;
      s1_red_a    <= 1'b0;
      s1_red_b    <= 1'b0;
      s1_op       <= '0;
      s1_byp_a    <= 1'b0;
      s1_byp_b    <= 1'b0;
      s1_dir      <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      err_r       <= 1'b0;
      leds_r      <= '0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_a      <= bus.A;
        s1_b      <= bus.B;
        s1_cin    <= bus.Cin;
        s1_serial <= bus.serial_in;
        s1_red_a  <= bus.red_op_A;
        s1_red_b  <= bus.red_op_B;
        s1_op     <= bus.opcode;
        s1_byp_a  <= bus.bypass_A;
        s1_byp_b  <= bus.bypass_B;
        s1_dir    <= bus.direction;
      end else if (load_s2) begin
        s1_valid <= 1'b0;
      end

      if (load_s2) begin
        out_valid_r <= 1'b1;
        out_r       <= res;
        err_r       <= invalid;
        if (invalid) leds_r <= ~leds_r;
      end else if (out_valid_r & bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef ALSU_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_r <= 8'h00;
    end else if (load_s2 & invalid & (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end
  end

  assign bus.err_cnt = err_cnt_r;
`else
  assign bus.err_cnt = 8'h00;
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.err       = err_r;
  assign bus.leds      = leds_r;
endmodule

// File: tb/tb_alsu_pipe.sv
// tb/tb_alsu_pipe.sv - self-checking bench for alsu_pipe against a behavioural model
module tb_alsu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;

  alsu_pipe_if #(.WIDTH(4)) bus();

  alsu_pipe #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out;
    logic        err;
    logic [15:0] leds;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_consumed = 0;
  logic [7:0] prev_out = 8'h00;
  int   inv_total = 0;
  bit   hold = 0;
  logic [7:0] held_out;
  logic held_err;
  bit   rand_ready = 0;
  bit   ready_val = 1;

`ifdef ALSU_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result from the operation rules, with out as plain integer arithmetic; bit 8 = err.
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                       input logic si, input logic ra, input logic rb,
                                       input logic [2:0] op, input logic ba, input logic bb,
                                       input logic dir, input logic [7:0] prev);
    int sa, sb, r, p;
    logic [3:0] x;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = int'(prev);
    r  = 0;
    if (op >= 3'd6 || ((ra || rb) && op >= 3'd2)) return {1'b1, 8'h00};
    if (ba || bb) begin
      r = ba ? sa : sb;
    end else if (op <= 3'd1 && (ra || rb)) begin
      x = ra ? a : b;
      r = (op == 3'd0) ? int'(x != 4'h0) : ($countones(x) % 2);
    end else begin
      case (op)
        3'd0: begin x = a | b; r = int'($signed(x)); end
        3'd1: begin x = a ^ b; r = int'($signed(x)); end
        3'd2: r = sa + sb + int'(cin);
        3'd3: r = sa * sb;
        3'd4: r = dir ? (p * 2 + int'(si)) : (int'(si) * 128 + p / 2);
        default: r = dir ? (p * 2 + p / 128) : ((p % 2) * 128 + p / 2);
      endcase
    end
    return {1'b0, r[7:0]};
  endfunction

  // Monitor: consumes results in order and pushes the model result of every accepted input.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] r;
    if (!rst) begin
      q.delete();
      prev_out = 8'h00;
      inv_total = 0;
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_out", {24'd0, bus.out}, {24'd0, held_out});
        check("hold_err", {31'd0, bus.err}, {31'd0, held_err});
      end
      hold = bus.out_valid && !bus.out_ready;
      held_out = bus.out;
      held_err = bus.err;
      if (bus.out_valid && bus.out_ready) begin
        n_consumed++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got out %0h with no pending transaction", bus.out);
        end else begin
          e = q.pop_front();
          check("res_out", {24'd0, bus.out}, {24'd0, e.out});
          check("res_err", {31'd0, bus.err}, {31'd0, e.err});
          check("res_leds", {16'd0, bus.leds}, {16'd0, e.leds});
          check("res_err_cnt", {24'd0, bus.err_cnt}, {24'd0, e.cnt});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        r = model(bus.A, bus.B, bus.Cin, bus.serial_in, bus.red_op_A, bus.red_op_B,
                  bus.opcode, bus.bypass_A, bus.bypass_B, bus.direction, prev_out);
        prev_out = r[7:0];
        if (r[8]) inv_total++;
        e.out  = r[7:0];
        e.err  = r[8];
        e.leds = (inv_total % 2 == 1) ? 16'hFFFF : 16'h0000;
        e.cnt  = CNT_EN ? ((inv_total > 255) ? 8'hFF : 8'(inv_total)) : 8'h00;
        q.push_back(e);
      end
    end
  end

  // Downstream ready, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? ($urandom % 3 != 0) : ready_val;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that took the transaction.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic cin = 0, input logic si = 0, input logic ra = 0,
                      input logic rb = 0, input logic ba = 0, input logic bb = 0,
                      input logic dir = 0);
    bit acc;
    bus.A = a; bus.B = b; bus.opcode = op; bus.Cin = cin; bus.serial_in = si;
    bus.red_op_A = ra; bus.red_op_B = rb; bus.bypass_A = ba; bus.bypass_B = bb;
    bus.direction = dir;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles");
    end
  endtask

  task automatic wait_out(input string name, input logic [7:0] exp_out, input logic exp_err);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        seen = 1;
        check({name, "_out"}, {24'd0, bus.out}, {24'd0, exp_out});
        check({name, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no result within 20 cycles", name);
    end
  endtask

  initial begin
    int c0;
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.Cin = 0; bus.serial_in = 0;
    bus.red_op_A = 0; bus.red_op_B = 0; bus.opcode = 0; bus.bypass_A = 0;
    bus.bypass_B = 0; bus.direction = 0;

    // Reset
    rst = 0;
    step();
    step();
    @(negedge clk);
    check("rst_out", {24'd0, bus.out}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_leds", {16'd0, bus.leds}, 32'd0);
    check("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    step();
    rst = 1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();

    // ADD with latency, then MUL
    send(4'd7, 4'd7, 3'b010, 1);
    @(negedge clk);
    check("add_latency_early", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("add_latency_valid", {31'd0, bus.out_valid}, 32'd1);
    check("add_out", {24'd0, bus.out}, 32'd15);
    step();
    send(4'h8, 4'h8, 3'b011);
    wait_out("mul", 8'd64, 0);
    step();

    // Back-to-back throughput
    c0 = n_consumed;
    send(4'd1, 4'd1, 3'b010);
    send(4'd2, 4'd1, 3'b010);
    send(4'd3, 4'd1, 3'b010);
    send(4'd4, 4'd1, 3'b010);
    step();
    check("b2b_three_done", n_consumed - c0, 32'd3);
    step();
    check("b2b_four_done", n_consumed - c0, 32'd4);
    check("b2b_drained_valid", {31'd0, bus.out_valid}, 32'd0);

    // Stall: two accepted, third blocked
    ready_val = 0;
    send(4'd1, 4'd2, 3'b010);
    send(4'd3, 4'd3, 3'b011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out", {24'd0, bus.out}, 32'd3);
      step();
    end
    ready_val = 1;
    wait_out("stall_r1", 8'd3, 0);
    wait_out("stall_r2", 8'd9, 0);
    step();

    // Reset mid-stream discards pending work
    ready_val = 0;
    send(4'd5, 4'd1, 3'b010);
    send(4'd6, 4'd1, 3'b010);
    rst = 0;
    step();
    step();
    rst = 1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out", {24'd0, bus.out}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    ready_val = 1;
    repeat (3) step();

    // Invalid transactions
    send(4'd1, 4'd1, 3'b110);
    wait_out("inv1", 8'd0, 1);
    check("inv1_leds", {16'd0, bus.leds}, 32'h0000FFFF);
    step();
    send(4'd1, 4'd1, 3'b010, 0, 0, 1);
    wait_out("inv2", 8'd0, 1);
    check("inv2_leds", {16'd0, bus.leds}, 32'h00000000);
    check("inv2_err_cnt", {24'd0, bus.err_cnt}, CNT_EN ? 32'd2 : 32'd0);
    step();

    // Bypass priority, shift, rotate
    send(4'd3, 4'hE, 3'b000, 0, 0, 0, 0, 1, 1);
    wait_out("byp_both", 8'h03, 0);
    step();
    send(4'd0, 4'd0, 3'b100, 0, 1, 0, 0, 0, 0, 1);
    wait_out("shl", 8'h07, 0);
    step();
    send(4'd1, 4'd0, 3'b000, 0, 0, 0, 0, 1, 0);
    wait_out("byp_a", 8'h01, 0);
    step();
    send(4'd0, 4'd0, 3'b101, 0, 0, 0, 0, 0, 0, 0);
    wait_out("rotr", 8'h80, 0);
    step();

    // Randomised traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom), 4'($urandom), 3'($urandom % 8), 1'($urandom), 1'($urandom),
           ($urandom % 6 == 0), ($urandom % 6 == 0), ($urandom % 6 == 0),
           ($urandom % 6 == 0), 1'($urandom));
      if ($urandom % 4 == 0) step();
    end
    rand_ready = 0;
    ready_val = 1;
    repeat (6) step();
    check("drain_empty", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
